// File: rtl/bitmap_sprite_engine_pkg.sv
// Shared types and helpers for the bouncing-dot bitmap engine.
package bitmap_sprite_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ERASE = 3'd2,
    ST_MOVE  = 3'd3,
    ST_PAINT = 3'd4
  } state_t;

  localparam int REFR_LINE_DEFAULT = 481;

  // Colour 0 is the erase value, so dot colours cycle through 1 .. 2**cw-1.
  function automatic int dot_color(input int i, input int cw);
    return (i % ((1 << cw) - 1)) + 1;
  endfunction

endpackage

// File: rtl/bitmap_sprite_engine_mover.sv
// Position and direction state of one dot, bouncing inside the bitmap on each move strobe.
module bitmap_sprite_engine_mover #(
  parameter int XW     = 7,
  parameter int YW     = 7,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          move,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  logic          x_down, y_down;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  assign x_nxt = x_down ? x - X_ONE : x + X_ONE;
  assign y_nxt = y_down ? y - Y_ONE : y + Y_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= XW'(INIT_X);
      y      <= YW'(INIT_Y);
      x_down <= 1'b0;
      y_down <= 1'b0;
    end else if (move) begin
      x <= x_nxt;
      y <= y_nxt;
      if (x_nxt == '1)      x_down <= 1'b1;
      else if (x_nxt == '0) x_down <= 1'b0;
      if (y_nxt == '1)      y_down <= 1'b1;
      else if (y_nxt == '0) y_down <= 1'b0;
    end
  end

endmodule

// File: rtl/xilinx_dual_port_ram_sync.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module xilinx_dual_port_ram_sync #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  // Registered read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) ram[addr_a] <= din_a;
    dout_b <= ram[addr_b];
  end

endmodule

// File: rtl/bitmap_sprite_engine.sv
// Frame sequencer that erases/moves/paints N_DOTS bouncing dots into a video RAM and
// maps the RAM onto the screen window for the RGB mux.
module bitmap_sprite_engine
  import bitmap_sprite_engine_pkg::*;
#(
  parameter int            XW        = 7,
  parameter int            YW        = 7,
  parameter int            CW        = 3,
  parameter int            N_DOTS    = 2,
  parameter int            ORG_X     = 0,
  parameter int            ORG_Y     = 0,
  parameter logic [CW-1:0] BG_COLOR  = 3'b110,
  parameter int            REFR_LINE = REFR_LINE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              mode,
  input  logic              clr,
  input  logic [N_DOTS-1:0] dot_en,
  output logic              busy,
  output logic              frame_miss,
  output logic [CW-1:0]     bitmap_rgb
);

  localparam int            IW       = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam int            AW       = XW + YW;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DOTS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [AW-1:0] clr_addr;
  logic          clr_pend;
  logic          tick;

  logic [XW-1:0] dot_x   [N_DOTS];
  logic [YW-1:0] dot_y   [N_DOTS];
  logic [CW-1:0] dot_col [N_DOTS];

  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [CW-1:0] sel_col;
  logic          sel_en;

  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;

  logic [XW-1:0] rel_x;
  logic [YW-1:0] rel_y;
  logic          in_win, in_win_d, video_on_d;
  logic [CW-1:0] dout;

  assign tick = (pix_y == 10'(REFR_LINE)) && (pix_x == 10'd0);
  assign busy = (state != ST_IDLE);

  for (genvar i = 0; i < N_DOTS; i++) begin : g_dot
    bitmap_sprite_engine_mover #(
      .XW(XW), .YW(YW), .INIT_X(4 * i), .INIT_Y(4 * i)
    ) u_mover (
      .clk   (clk),
      .reset (reset),
      .move  (state == ST_MOVE && dot_en[i]),
      .x     (dot_x[i]),
      .y     (dot_y[i])
    );
    assign dot_col[i] = CW'(dot_color(i, CW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      clr_addr   <= '0;
      clr_pend   <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      // A tick is lost whenever the sequencer cannot start a frame on it.
      frame_miss <= tick && (state != ST_IDLE || clr || clr_pend);
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (clr || clr_pend) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            clr_pend <= 1'b0;
          end else if (tick) begin
            state <= mode ? ST_ERASE : ST_MOVE;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == '1) state <= ST_IDLE;
        end
        ST_ERASE: begin
          clr_pend <= clr_pend | clr;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_MOVE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_MOVE: begin
          clr_pend <= clr_pend | clr;
          idx      <= '0;
          state    <= ST_PAINT;
        end
        ST_PAINT: begin
          clr_pend <= clr_pend | clr;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_col = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < N_DOTS; i++) begin
      if (idx == IW'(i)) begin
        sel_x   = dot_x[i];
        sel_y   = dot_y[i];
        sel_col = dot_col[i];
        sel_en  = dot_en[i];
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    case (state)
      ST_CLEAR: we = 1'b1;
      ST_ERASE: begin
        we    = sel_en;
        waddr = {sel_y, sel_x};
      end
      ST_PAINT: begin
        we    = sel_en;
        waddr = {sel_y, sel_x};
        wdata = sel_col;
      end
      default: we = 1'b0;
    endcase
  end

  // Read side: window test and address are aligned with the one-cycle RAM read.
  assign rel_x  = XW'(pix_x - 10'(ORG_X));
  assign rel_y  = YW'(pix_y - 10'(ORG_Y));
  assign in_win = (int'(pix_x) >= ORG_X) && (int'(pix_x) - ORG_X < (1 << XW)) &&
                  (int'(pix_y) >= ORG_Y) && (int'(pix_y) - ORG_Y < (1 << YW));

  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_d <= 1'b0;
      in_win_d   <= 1'b0;
    end else begin
      video_on_d <= video_on;
      in_win_d   <= in_win;
    end
  end

  xilinx_dual_port_ram_sync #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(CW)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .addr_a (waddr),
    .addr_b ({rel_y, rel_x}),
    .din_a  (wdata),
    .dout_b (dout)
  );

  assign bitmap_rgb = !video_on_d ? '0 : (in_win_d ? dout : BG_COLOR);

endmodule

// File: tb/tb_bitmap_sprite_engine.sv
// Directed bench for bitmap_sprite_engine with default parameters (128x128, 2 dots).
module tb_bitmap_sprite_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pix_x, pix_y;
  logic       mode;
  logic       clr;
  logic [1:0] dot_en;
  logic       busy;
  logic       frame_miss;
  logic [2:0] bitmap_rgb;

  int checks = 0;
  int errors = 0;

  bitmap_sprite_engine dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .mode       (mode),
    .clr        (clr),
    .dot_en     (dot_en),
    .busy       (busy),
    .frame_miss (frame_miss),
    .bitmap_rgb (bitmap_rgb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Fires one frame tick and counts the cycles busy stays high afterwards.
  task automatic do_tick(output int n);
    pix_x = 10'd0;
    pix_y = 10'd481;
    step();
    pix_y = 10'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic read_px(input int x, input int y, output logic [2:0] c);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = 1'b1;
    step();
    c = bitmap_rgb;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    video_on = 1'b1;
    pix_x    = 10'd200;
    pix_y    = 10'd10;
    mode     = 1'b0;
    clr      = 1'b0;
    dot_en   = 2'b11;
    repeat (3) step();
    checks++;
    if (bitmap_rgb !== 3'd0) begin
      errors++;
      $display("FAIL reset_rgb: got %0d expected 0", bitmap_rgb);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || frame_miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%0b frame_miss=%0b expected 0/0", busy, frame_miss);
    end
    checks++;
    if (bitmap_rgb !== 3'b110) begin
      errors++;
      $display("FAIL bg_color: got %0d expected 6", bitmap_rgb);
    end
    video_on = 1'b0;
    step();
    checks++;
    if (bitmap_rgb !== 3'd0) begin
      errors++;
      $display("FAIL blank_rgb: got %0d expected 0", bitmap_rgb);
    end
  endtask

  task automatic test_clear();
    int n;
    int nz;
    logic [2:0] c;
    // clr and tick together: clear wins, tick is reported lost
    clr   = 1'b1;
    pix_x = 10'd0;
    pix_y = 10'd481;
    step();
    clr   = 1'b0;
    pix_y = 10'd0;
    checks++;
    if (frame_miss !== 1'b1) begin
      errors++;
      $display("FAIL clr_tick_miss: got %0b expected 1", frame_miss);
    end
    n = busy ? 1 : 0;
    while (busy && n < 20000) begin
      step();
      if (busy) n++;
    end
    checks++;
    if (n != 16384) begin
      errors++;
      $display("FAIL clear_len: got %0d expected 16384", n);
    end
    nz = 0;
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) begin
        read_px(x, y, c);
        if (c !== 3'd0) nz++;
      end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL clear_scan: nonzero pixels %0d expected 0", nz);
    end
  endtask

  task automatic test_trail();
    int n;
    logic [2:0] c;
    mode = 1'b0;
    do_tick(n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL trail_busy1: got %0d expected 3", n); end
    read_px(1, 1, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL trail_p11: got %0d expected 1", c); end
    read_px(5, 5, c);
    checks++;
    if (c !== 3'd2) begin errors++; $display("FAIL trail_p55: got %0d expected 2", c); end
    read_px(0, 0, c);
    checks++;
    if (c !== 3'd0) begin errors++; $display("FAIL trail_p00: got %0d expected 0", c); end
    do_tick(n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL trail_busy2: got %0d expected 3", n); end
    read_px(2, 2, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL trail_p22: got %0d expected 1", c); end
    read_px(6, 6, c);
    checks++;
    if (c !== 3'd2) begin errors++; $display("FAIL trail_p66: got %0d expected 2", c); end
    read_px(1, 1, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL trail_kept11: got %0d expected 1", c); end
  endtask

  task automatic test_single();
    int n1, n2;
    logic [2:0] c;
    apply_reset();
    mode = 1'b1;
    do_tick(n1);
    do_tick(n2);
    checks++;
    if (n1 != 5 || n2 != 5) begin
      errors++;
      $display("FAIL single_busy: got %0d,%0d expected 5,5", n1, n2);
    end
    read_px(1, 1, c);
    checks++;
    if (c !== 3'd0) begin errors++; $display("FAIL single_p11: got %0d expected 0", c); end
    read_px(5, 5, c);
    checks++;
    if (c !== 3'd0) begin errors++; $display("FAIL single_p55: got %0d expected 0", c); end
    read_px(2, 2, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL single_p22: got %0d expected 1", c); end
    read_px(6, 6, c);
    checks++;
    if (c !== 3'd2) begin errors++; $display("FAIL single_p66: got %0d expected 2", c); end
  endtask

  task automatic test_bounce();
    int n;
    int bad;
    logic [2:0] c;
    apply_reset();
    mode   = 1'b1;
    dot_en = 2'b01;
    bad    = 0;
    for (int k = 0; k < 127; k++) begin
      do_tick(n);
      if (n != 5) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bounce_busy: bad frames %0d expected 0", bad); end
    read_px(127, 127, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL edge_p127: got %0d expected 1", c); end
    read_px(126, 126, c);
    checks++;
    if (c !== 3'd0) begin errors++; $display("FAIL edge_p126_pre: got %0d expected 0", c); end
    do_tick(n);
    read_px(126, 126, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL bounce_p126: got %0d expected 1", c); end
    read_px(127, 127, c);
    checks++;
    if (c !== 3'd0) begin errors++; $display("FAIL bounce_p127: got %0d expected 0", c); end
    // dot1 was frozen at (4,4) throughout, so its next step lands on (5,5)
    dot_en = 2'b10;
    do_tick(n);
    read_px(5, 5, c);
    checks++;
    if (c !== 3'd2) begin errors++; $display("FAIL dot1_frozen: got %0d expected 2", c); end
    read_px(126, 126, c);
    checks++;
    if (c !== 3'd1) begin errors++; $display("FAIL dot0_disabled: got %0d expected 1", c); end
    dot_en = 2'b11;
  endtask

  task automatic test_clear_pending();
    int n;
    mode  = 1'b0;
    pix_x = 10'd0;
    pix_y = 10'd481;
    step();
    // state MOVE now; a second tick here must be dropped
    step();
    pix_y = 10'd0;
    checks++;
    if (frame_miss !== 1'b1) begin errors++; $display("FAIL busy_tick_miss: got %0b expected 1", frame_miss); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (frame_miss !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL paint_phase: frame_miss=%0b busy=%0b expected 0/1", frame_miss, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL pend_idle: busy=%0b expected 0", busy); end
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pend_clear_start: busy=%0b expected 1", busy); end
    n = busy ? 1 : 0;
    // tick and a stray clr during CLEAR
    pix_y = 10'd481;
    clr   = 1'b1;
    step();
    pix_y = 10'd0;
    clr   = 1'b0;
    if (busy) n++;
    checks++;
    if (frame_miss !== 1'b1) begin errors++; $display("FAIL clear_tick_miss: got %0b expected 1", frame_miss); end
    step();
    if (busy) n++;
    checks++;
    if (frame_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse_len: got %0b expected 0", frame_miss); end
    while (busy && n < 20000) begin
      step();
      if (busy) n++;
    end
    checks++;
    if (n != 16384) begin errors++; $display("FAIL pend_clear_len: got %0d expected 16384", n); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clr_ignored: busy=%0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_trail();
    test_single();
    test_bounce();
    test_clear_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
